// File: rtl/traffic_phase_sequencer.sv
// Intersection phase sequencer: steps NS/EW greens through yellow and all-red clearance,
// inserts a pedestrian walk phase on request, and reloads the external countdown timer on every phase entry.
module traffic_phase_sequencer #(
    parameter int TW       = 4,
    parameter int T_GREEN  = 5,
    parameter int T_YELLOW = 2,
    parameter int T_ALLRED = 1,
    parameter int T_WALK   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          car_ns,
    input  logic          car_ew,
    input  logic          ped,
    input  logic [TW-1:0] timer_out,
    output logic          timer_en,
    output logic          timer_load,
    output logic [TW-1:0] timer_init,
    output logic [2:0]    light_ns,
    output logic [2:0]    light_ew,
    output logic [1:0]    light_ped
);

    typedef enum logic [2:0] {
        ST_NS_G    = 3'd0,
        ST_NS_Y    = 3'd1,
        ST_ALL_RED = 3'd2,
        ST_EW_G    = 3'd3,
        ST_EW_Y    = 3'd4,
        ST_PED     = 3'd5
    } state_t;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    localparam logic [TW-1:0] DUR_GREEN  = TW'(T_GREEN);
    localparam logic [TW-1:0] DUR_YELLOW = TW'(T_YELLOW);
    localparam logic [TW-1:0] DUR_ALLRED = TW'(T_ALLRED);
    localparam logic [TW-1:0] DUR_WALK   = TW'(T_WALK);

    state_t state_r;
    state_t state_nxt_s;
    logic   last_dir_r;
    logic   last_dir_nxt_s;
    logic   req_ns_r;
    logic   req_ew_r;
    logic   req_ped_r;
    logic   expired_s;
    logic   clr_ns_s;
    logic   clr_ew_s;
    logic   clr_ped_s;

    function automatic logic [TW-1:0] dur_of(input state_t s);
        case (s)
            ST_NS_G:    dur_of = DUR_GREEN;
            ST_EW_G:    dur_of = DUR_GREEN;
            ST_NS_Y:    dur_of = DUR_YELLOW;
            ST_EW_Y:    dur_of = DUR_YELLOW;
            ST_ALL_RED: dur_of = DUR_ALLRED;
            ST_PED:     dur_of = DUR_WALK;
            default:    dur_of = DUR_GREEN;
        endcase
    endfunction

    // Anything other than an NS green/yellow shows NS red, so a corrupt state fails safe.
    function automatic logic [2:0] ns_lamp(input state_t s);
        case (s)
            ST_NS_G: ns_lamp = 3'b001;
            ST_NS_Y: ns_lamp = 3'b010;
            default: ns_lamp = 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input state_t s);
        case (s)
            ST_EW_G: ew_lamp = 3'b001;
            ST_EW_Y: ew_lamp = 3'b010;
            default: ew_lamp = 3'b100;
        endcase
    endfunction

    function automatic logic [1:0] ped_lamp(input state_t s);
        case (s)
            ST_PED:  ped_lamp = 2'b01;
            default: ped_lamp = 2'b10;
        endcase
    endfunction

    // A stale zero on timer_out during a load cycle must not count as expiry.
    assign expired_s = (timer_out == {TW{1'b0}}) & ~timer_load;

    // Request clear strobes fire in the load cycle of the state that serves them.
    always_comb begin
        clr_ns_s  = 1'b0;
        clr_ew_s  = 1'b0;
        clr_ped_s = 1'b0;
        if (timer_load) begin
            clr_ns_s  = (state_r == ST_NS_G);
            clr_ew_s  = (state_r == ST_EW_G);
            clr_ped_s = (state_r == ST_PED);
        end else begin
            clr_ns_s  = 1'b0;
            clr_ew_s  = 1'b0;
            clr_ped_s = 1'b0;
        end
    end

    // Next-phase selection; every move waits for timer expiry except recovery from an illegal encoding.
    always_comb begin
        state_nxt_s    = state_r;
        last_dir_nxt_s = last_dir_r;
        case (state_r)
            ST_NS_G: begin
                if (expired_s && (req_ew_r || req_ped_r)) begin
                    state_nxt_s = ST_NS_Y;
                end else begin
                    state_nxt_s = ST_NS_G;
                end
            end
            ST_EW_G: begin
                if (expired_s && (req_ns_r || req_ped_r)) begin
                    state_nxt_s = ST_EW_Y;
                end else begin
                    state_nxt_s = ST_EW_G;
                end
            end
            ST_NS_Y: begin
                if (expired_s) begin
                    state_nxt_s    = ST_ALL_RED;
                    last_dir_nxt_s = DIR_NS;
                end else begin
                    state_nxt_s = ST_NS_Y;
                end
            end
            ST_EW_Y: begin
                if (expired_s) begin
                    state_nxt_s    = ST_ALL_RED;
                    last_dir_nxt_s = DIR_EW;
                end else begin
                    state_nxt_s = ST_EW_Y;
                end
            end
            ST_ALL_RED: begin
                if (!expired_s) begin
                    state_nxt_s = ST_ALL_RED;
                end else if (req_ped_r) begin
                    state_nxt_s = ST_PED;
                end else if (last_dir_r == DIR_NS) begin
                    state_nxt_s = ST_EW_G;
                end else begin
                    state_nxt_s = ST_NS_G;
                end
            end
            ST_PED: begin
                // Prefer the direction that did not just run, if it is waiting.
                if (!expired_s) begin
                    state_nxt_s = ST_PED;
                end else if (last_dir_r == DIR_NS) begin
                    state_nxt_s = req_ew_r ? ST_EW_G : ST_NS_G;
                end else begin
                    state_nxt_s = req_ns_r ? ST_NS_G : ST_EW_G;
                end
            end
            default: begin
                state_nxt_s    = ST_NS_G;
                last_dir_nxt_s = DIR_NS;
            end
        endcase
    end

    // Phase register, sticky requests, timer control and registered light decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_NS_G;
            last_dir_r <= DIR_NS;
            req_ns_r   <= 1'b0;
            req_ew_r   <= 1'b0;
            req_ped_r  <= 1'b0;
            timer_en   <= 1'b0;
            timer_load <= 1'b1;
            timer_init <= DUR_GREEN;
            light_ns   <= 3'b001;
            light_ew   <= 3'b100;
            light_ped  <= 2'b10;
        end else begin
            state_r    <= state_nxt_s;
            last_dir_r <= last_dir_nxt_s;
            req_ns_r   <= (req_ns_r  & ~clr_ns_s)  | car_ns;
            req_ew_r   <= (req_ew_r  & ~clr_ew_s)  | car_ew;
            req_ped_r  <= (req_ped_r & ~clr_ped_s) | ped;
            timer_en   <= 1'b1;
            if (state_nxt_s != state_r) begin
                timer_load <= 1'b1;
                timer_init <= dur_of(state_nxt_s);
            end else begin
                timer_load <= 1'b0;
                timer_init <= timer_init;
            end
            light_ns  <= ns_lamp(state_nxt_s);
            light_ew  <= ew_lamp(state_nxt_s);
            light_ped <= ped_lamp(state_nxt_s);
        end
    end

endmodule
